counter_with_k_cnt: RTL and testbench
=====================================

COUNTER_WITH_K_CNT -- requirements
Module: counter_with_k_cnt

Interface
REQ-001 Parameter N, default 3, counter width in bits (N >= 2).
REQ-002 Parameter K, default 2, number of count-enable inputs (1 <= K < MOD).
REQ-003 Parameter MOD, default 2**N, modulus (2 <= MOD <= 2**N); legal count range is 0..MOD-1.
REQ-004 Parameter SAT, default 0, overflow mode: 0 = wrap, 1 = saturate.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  reset, synchronous and active-low.
REQ-007 cnt  input  K  count enables; each asserted bit contributes +1 (or -1) to this cycle's step.
REQ-008 dn  input  1  direction: 0 = up, 1 = down.
REQ-009 clr  input  1  synchronous clear to 0.
REQ-010 ld  input  1  synchronous load of ld_val.
REQ-011 ld_val  input  N  load value; values >= MOD are reduced to MOD-1.
REQ-012 count  output  N  registered counter value.
REQ-013 co  output  1  registered one-cycle carry/borrow pulse.
REQ-014 sat  output  1  registered sticky saturation flag (SAT=1 only; tied 0 when SAT=0).
REQ-015 zero  output  1  combinational, high when count == 0.

Function
REQ-016 step SHALL equal popcount(cnt), range 0..K; step == 0 holds count and drives co low.
REQ-017 Priority SHALL be: rst low > clr > ld > counting.
REQ-018 clr SHALL set count=0, co=0, sat=0 on the next edge.
REQ-019 ld SHALL set count=min(ld_val, MOD-1), co=0, sat=0 on the next edge, ignoring cnt.
REQ-020 Up arithmetic SHALL use N+1-bit sum s = count + step with no intermediate truncation.
REQ-021 Up, s < MOD: count <= s, co <= 0.
REQ-022 Up, s >= MOD, SAT=0: count <= s - MOD, co <= 1 for exactly one cycle.
REQ-023 Up, s >= MOD, SAT=1: count <= MOD-1, co <= 1 for one cycle, sat <= 1.
REQ-024 Down, count >= step: count <= count - step, co <= 0.
REQ-025 Down, count < step, SAT=0: count <= count + MOD - step, co <= 1 for one cycle.
REQ-026 Down, count < step, SAT=1: count <= 0, co <= 1 for one cycle, sat <= 1.
REQ-027 In saturate mode, further counting against the held limit SHALL keep count at the limit and pulse co again on each such cycle.
REQ-028 Counting in the opposite direction after saturation SHALL proceed normally; sat stays 1 until clr, ld or reset.
REQ-029 co SHALL never be asserted in two cycles for one event; back-to-back wrap events SHALL produce back-to-back pulses.
REQ-030 Latency: every input takes effect on count, co and sat at the first rising edge after it is applied; zero follows count combinationally.

Reset
REQ-031 While rst is low at a rising edge: count=0, co=0, sat=0, therefore zero=1.
REQ-032 Reset asserted mid-count SHALL discard any concurrent clr, ld or cnt activity.
REQ-033 Counting SHALL resume on the first edge with rst high.

Structure
REQ-034 The mode constants (SAT_WRAP=0, SAT_HOLD=1) SHALL live in the shared counter include file, not locally.
REQ-035 popcount SHALL be a separate sub-module cnt_popcount, parameterised on K, output width clog2(K+1).
REQ-036 Arithmetic and next-state logic SHALL be combinational, and a single registered block SHALL hold count, co and sat.

Verification
REQ-037 Legacy (N=3, K=2, MOD=8, SAT=0): rst low 2 cycles -> count=0, zero=1, co=0; then cnt=2'b01 for 3 cycles -> count=3.
REQ-038 Legacy wrap: count=6, cnt=2'b11, dn=0 -> count=0 and co=1 for one cycle; next cycle with cnt=2'b00 -> co=0.
REQ-039 Modulus (N=4, K=3, MOD=10, SAT=0): ld_val=8, then cnt=3'b111 -> count=1, co=1; dn=1 with cnt=3'b011 from count 1 -> count=9, co=1.
REQ-040 Saturate (N=3, K=2, MOD=8, SAT=1): count=7 with cnt=2'b11 for 3 cycles -> count stays 7, co=1 each cycle, sat=1; then dn=1, cnt=2'b01 -> count=6, sat remains 1.
REQ-041 Priority: clr=1, ld=1, ld_val=5, cnt=2'b11 together -> count=0; ld=1 alone with ld_val=12 (MOD=10) -> count=9.
REQ-042 Reset mid-count: rst low during cnt=2'b11 at count=5 -> count=0, co=0, sat=0 at that edge.

Source files
------------

// File: rtl/counter_with_k_cnt_pkg.sv
// Shared constants for the multi-enable counter family.
package counter_with_k_cnt_pkg;

    localparam int unsigned SAT_WRAP = 0;
    localparam int unsigned SAT_HOLD = 1;

endpackage

// File: rtl/cnt_popcount.sv
// Counts the asserted bits of a K-bit enable vector.
module cnt_popcount #(
    parameter int unsigned K = 2
) (
    input  logic [K-1:0]             in_i,
    output logic [$clog2(K+1)-1:0]   pop_o
);

    localparam int unsigned W = $clog2(K + 1);

    always_comb begin
        pop_o = '0;
        for (int i = 0; i < K; i++) begin
            pop_o = pop_o + W'(in_i[i]);
        end
    end

endmodule

// File: rtl/counter_with_k_cnt.sv
// Modulo-MOD up/down counter stepping by the number of asserted enables, wrap or saturate.
module counter_with_k_cnt
    import counter_with_k_cnt_pkg::*;
#(
    parameter int unsigned N   = 3,
    parameter int unsigned K   = 2,
    parameter int unsigned MOD = 2 ** N,
    parameter int unsigned SAT = SAT_WRAP
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [K-1:0] cnt,
    input  logic         dn,
    input  logic         clr,
    input  logic         ld,
    input  logic [N-1:0] ld_val,
    output logic [N-1:0] count,
    output logic         co,
    output logic         sat,
    output logic         zero
);

    localparam int unsigned SW    = $clog2(K + 1);
    localparam logic [N:0]  MOD_W = (N + 1)'(MOD);
    localparam logic [N:0]  MAX_W = (N + 1)'(MOD - 1);

    logic [SW-1:0] step;
    logic [N:0]    step_w;
    logic [N:0]    count_w;
    logic [N:0]    sum_w;
    logic [N:0]    wrap_up_w;
    logic [N:0]    wrap_dn_w;
    logic [N:0]    diff_w;
    logic [N:0]    ld_w;
    logic [N-1:0]  count_d, count_q;
    logic          co_d, co_q;
    logic          sat_d, sat_q;

    cnt_popcount #(
        .K (K)
    ) u_popcount (
        .in_i  (cnt),
        .pop_o (step)
    );

    // All arithmetic is N+1 bits wide so count + step and count + MOD never truncate.
    always_comb begin
        step_w    = (N + 1)'(step);
        count_w   = {1'b0, count_q};
        sum_w     = count_w + step_w;
        wrap_up_w = sum_w - MOD_W;
        diff_w    = count_w - step_w;
        wrap_dn_w = count_w + MOD_W - step_w;
        ld_w      = ({1'b0, ld_val} >= MOD_W) ? MAX_W : {1'b0, ld_val};

        count_d = count_q;
        co_d    = 1'b0;
        sat_d   = sat_q;

        if (clr) begin
            count_d = '0;
            sat_d   = 1'b0;
        end else if (ld) begin
            count_d = ld_w[N-1:0];
            sat_d   = 1'b0;
        end else if (step != '0) begin
            if (!dn) begin
                if (sum_w < MOD_W) begin
                    count_d = sum_w[N-1:0];
                end else if (SAT == SAT_HOLD) begin
                    count_d = MAX_W[N-1:0];
                    co_d    = 1'b1;
                    sat_d   = 1'b1;
                end else begin
                    count_d = wrap_up_w[N-1:0];
                    co_d    = 1'b1;
                end
            end else begin
                if (count_w >= step_w) begin
                    count_d = diff_w[N-1:0];
                end else if (SAT == SAT_HOLD) begin
                    count_d = '0;
                    co_d    = 1'b1;
                    sat_d   = 1'b1;
                end else begin
                    count_d = wrap_dn_w[N-1:0];
                    co_d    = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= '0;
            co_q    <= 1'b0;
            sat_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            co_q    <= co_d;
            sat_q   <= sat_d;
        end
    end

    assign count = count_q;
    assign co    = co_q;
    assign sat   = sat_q;
    assign zero  = (count_q == '0);

endmodule

// File: tb/tb_counter_with_k_cnt.sv
// Directed vector bench for three counter configurations: legacy wrap, MOD=10, saturate.
module tb_counter_with_k_cnt;

    typedef struct {
        string      name;
        logic       rst;
        logic       clr;
        logic       ld;
        logic [3:0] ld_val;
        logic       dn;
        logic [2:0] cnt;
        logic [3:0] exp_count;
        logic       exp_co;
        logic       exp_sat;
        logic       exp_zero;
    } vec_t;

    int total = 0;
    int bad   = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: N=3 K=2 MOD=8 wrap
    logic       rst_a, clr_a, ld_a, dn_a;
    logic [1:0] cnt_a;
    logic [2:0] ld_val_a, count_a;
    logic       co_a, sat_a, zero_a;

    // DUT B: N=4 K=3 MOD=10 wrap
    logic       rst_b, clr_b, ld_b, dn_b;
    logic [2:0] cnt_b;
    logic [3:0] ld_val_b, count_b;
    logic       co_b, sat_b, zero_b;

    // DUT C: N=3 K=2 MOD=8 saturate
    logic       rst_c, clr_c, ld_c, dn_c;
    logic [1:0] cnt_c;
    logic [2:0] ld_val_c, count_c;
    logic       co_c, sat_c, zero_c;

    counter_with_k_cnt #(.N(3), .K(2), .MOD(8), .SAT(0)) u_dut_a (
        .clk (clk), .rst (rst_a), .cnt (cnt_a), .dn (dn_a), .clr (clr_a), .ld (ld_a),
        .ld_val (ld_val_a), .count (count_a), .co (co_a), .sat (sat_a), .zero (zero_a)
    );

    counter_with_k_cnt #(.N(4), .K(3), .MOD(10), .SAT(0)) u_dut_b (
        .clk (clk), .rst (rst_b), .cnt (cnt_b), .dn (dn_b), .clr (clr_b), .ld (ld_b),
        .ld_val (ld_val_b), .count (count_b), .co (co_b), .sat (sat_b), .zero (zero_b)
    );

    counter_with_k_cnt #(.N(3), .K(2), .MOD(8), .SAT(1)) u_dut_c (
        .clk (clk), .rst (rst_c), .cnt (cnt_c), .dn (dn_c), .clr (clr_c), .ld (ld_c),
        .ld_val (ld_val_c), .count (count_c), .co (co_c), .sat (sat_c), .zero (zero_c)
    );

    function automatic vec_t mk(string name, logic rst, logic clr, logic ld, logic [3:0] ld_val,
                                logic dn, logic [2:0] cnt, logic [3:0] ec, logic eco,
                                logic esat, logic ez);
        vec_t v;
        v.name = name; v.rst = rst; v.clr = clr; v.ld = ld; v.ld_val = ld_val;
        v.dn = dn; v.cnt = cnt; v.exp_count = ec; v.exp_co = eco; v.exp_sat = esat;
        v.exp_zero = ez;
        return v;
    endfunction

    task automatic check(string name, string field, logic [3:0] act, logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s: got %0d, expected %0d", name, field, act, exp);
        end
    endtask

    task automatic apply(int d, vec_t t);
        logic [3:0] a_count;
        logic       a_co, a_sat, a_zero;
        case (d)
            0: begin
                rst_a = t.rst; clr_a = t.clr; ld_a = t.ld; dn_a = t.dn;
                ld_val_a = t.ld_val[2:0]; cnt_a = t.cnt[1:0];
            end
            1: begin
                rst_b = t.rst; clr_b = t.clr; ld_b = t.ld; dn_b = t.dn;
                ld_val_b = t.ld_val; cnt_b = t.cnt;
            end
            default: begin
                rst_c = t.rst; clr_c = t.clr; ld_c = t.ld; dn_c = t.dn;
                ld_val_c = t.ld_val[2:0]; cnt_c = t.cnt[1:0];
            end
        endcase
        @(posedge clk);
        #1;
        case (d)
            0:       begin a_count = {1'b0, count_a}; a_co = co_a; a_sat = sat_a; a_zero = zero_a; end
            1:       begin a_count = count_b; a_co = co_b; a_sat = sat_b; a_zero = zero_b; end
            default: begin a_count = {1'b0, count_c}; a_co = co_c; a_sat = sat_c; a_zero = zero_c; end
        endcase
        check(t.name, "count", a_count, t.exp_count);
        check(t.name, "co", {3'b0, a_co}, {3'b0, t.exp_co});
        check(t.name, "sat", {3'b0, a_sat}, {3'b0, t.exp_sat});
        check(t.name, "zero", {3'b0, a_zero}, {3'b0, t.exp_zero});
    endtask

    vec_t tbl_a[$];
    vec_t tbl_b[$];
    vec_t tbl_c[$];

    initial begin
        rst_a = 0; clr_a = 0; ld_a = 0; dn_a = 0; cnt_a = '0; ld_val_a = '0;
        rst_b = 0; clr_b = 0; ld_b = 0; dn_b = 0; cnt_b = '0; ld_val_b = '0;
        rst_c = 0; clr_c = 0; ld_c = 0; dn_c = 0; cnt_c = '0; ld_val_c = '0;

        //                 name        rst clr ld ldv dn cnt     cnt co sat z
        tbl_a.push_back(mk("a_rst0",    0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));
        tbl_a.push_back(mk("a_rst1",    0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));
        tbl_a.push_back(mk("a_up1",     1, 0, 0, 0, 0, 3'b001, 1, 0, 0, 0));
        tbl_a.push_back(mk("a_up2",     1, 0, 0, 0, 0, 3'b001, 2, 0, 0, 0));
        tbl_a.push_back(mk("a_up3",     1, 0, 0, 0, 0, 3'b001, 3, 0, 0, 0));
        tbl_a.push_back(mk("a_ld6",     1, 0, 1, 6, 0, 3'b011, 6, 0, 0, 0));
        tbl_a.push_back(mk("a_wrap",    1, 0, 0, 0, 0, 3'b011, 0, 1, 0, 1));
        tbl_a.push_back(mk("a_idle",    1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));
        tbl_a.push_back(mk("a_dnwrap",  1, 0, 0, 0, 1, 3'b011, 6, 1, 0, 0));
        tbl_a.push_back(mk("a_dn1",     1, 0, 0, 0, 1, 3'b010, 5, 0, 0, 0));
        tbl_a.push_back(mk("a_rstmid",  0, 1, 1, 3, 0, 3'b011, 0, 0, 0, 1));
        tbl_a.push_back(mk("a_resume",  1, 0, 0, 0, 0, 3'b011, 2, 0, 0, 0));
        tbl_a.push_back(mk("a_clrpri",  1, 1, 1, 5, 0, 3'b011, 0, 0, 0, 1));

        tbl_b.push_back(mk("b_rst",     0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));
        tbl_b.push_back(mk("b_ld8",     1, 0, 1, 8, 0, 3'b000, 8, 0, 0, 0));
        tbl_b.push_back(mk("b_upwrap",  1, 0, 0, 0, 0, 3'b111, 1, 1, 0, 0));
        tbl_b.push_back(mk("b_dnwrap",  1, 0, 0, 0, 1, 3'b011, 9, 1, 0, 0));
        tbl_b.push_back(mk("b_hold",    1, 0, 0, 0, 1, 3'b000, 9, 0, 0, 0));
        tbl_b.push_back(mk("b_clrpri",  1, 1, 1, 5, 0, 3'b111, 0, 0, 0, 1));
        tbl_b.push_back(mk("b_ld12",    1, 0, 1, 12, 0, 3'b000, 9, 0, 0, 0));
        tbl_b.push_back(mk("b_ld3",     1, 0, 1, 3, 0, 3'b111, 3, 0, 0, 0));
        tbl_b.push_back(mk("b_ld15",    1, 0, 1, 15, 0, 3'b000, 9, 0, 0, 0));
        tbl_b.push_back(mk("b_ld10",    1, 0, 1, 10, 0, 3'b000, 9, 0, 0, 0));
        tbl_b.push_back(mk("b_ld9",     1, 0, 1, 9, 0, 3'b000, 9, 0, 0, 0));
        tbl_b.push_back(mk("b_ld3b",    1, 0, 1, 3, 0, 3'b000, 3, 0, 0, 0));
        tbl_b.push_back(mk("b_up2",     1, 0, 0, 0, 0, 3'b101, 5, 0, 0, 0));
        tbl_b.push_back(mk("b_dn3",     1, 0, 0, 0, 1, 3'b111, 2, 0, 0, 0));
        tbl_b.push_back(mk("b_dn3wrap", 1, 0, 0, 0, 1, 3'b111, 9, 1, 0, 0));

        tbl_c.push_back(mk("c_rst",     0, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));
        tbl_c.push_back(mk("c_ld7",     1, 0, 1, 7, 0, 3'b000, 7, 0, 0, 0));
        tbl_c.push_back(mk("c_sat1",    1, 0, 0, 0, 0, 3'b011, 7, 1, 1, 0));
        tbl_c.push_back(mk("c_sat2",    1, 0, 0, 0, 0, 3'b011, 7, 1, 1, 0));
        tbl_c.push_back(mk("c_sat3",    1, 0, 0, 0, 0, 3'b011, 7, 1, 1, 0));
        tbl_c.push_back(mk("c_back",    1, 0, 0, 0, 1, 3'b001, 6, 0, 1, 0));
        tbl_c.push_back(mk("c_idle",    1, 0, 0, 0, 1, 3'b000, 6, 0, 1, 0));
        tbl_c.push_back(mk("c_ld5",     1, 0, 1, 5, 0, 3'b000, 5, 0, 0, 0));
        tbl_c.push_back(mk("c_up7",     1, 0, 0, 0, 0, 3'b011, 7, 0, 0, 0));
        tbl_c.push_back(mk("c_sat4",    1, 0, 0, 0, 0, 3'b001, 7, 1, 1, 0));
        tbl_c.push_back(mk("c_dn2",     1, 0, 0, 0, 1, 3'b011, 5, 0, 1, 0));
        tbl_c.push_back(mk("c_rstmid",  0, 0, 1, 7, 0, 3'b011, 0, 0, 0, 1));
        tbl_c.push_back(mk("c_dnsat",   1, 0, 0, 0, 1, 3'b001, 0, 1, 1, 1));
        tbl_c.push_back(mk("c_dnsat2",  1, 0, 0, 0, 1, 3'b011, 0, 1, 1, 1));
        tbl_c.push_back(mk("c_clr",     1, 1, 0, 0, 1, 3'b011, 0, 0, 0, 1));

        foreach (tbl_a[i]) apply(0, tbl_a[i]);
        foreach (tbl_b[i]) apply(1, tbl_b[i]);
        foreach (tbl_c[i]) apply(2, tbl_c[i]);

        // Back-to-back wrap events: each must give its own one-cycle pulse.
        apply(0, mk("a_seq_ld0",  1, 0, 1, 0, 0, 3'b000, 0, 0, 0, 1));
        apply(0, mk("a_seq_bw1",  1, 0, 0, 0, 1, 3'b001, 7, 1, 0, 0));
        apply(0, mk("a_seq_bw2",  1, 0, 0, 0, 0, 3'b001, 0, 1, 0, 1));
        apply(0, mk("a_seq_bw3",  1, 0, 0, 0, 0, 3'b010, 1, 0, 0, 0));
        apply(0, mk("a_seq_up",   1, 0, 0, 0, 0, 3'b011, 3, 0, 0, 0));

        // Load with enables active ignores the step; counting resumes next edge.
        apply(1, mk("b_seq_ld",   1, 0, 1, 7, 1, 3'b111, 7, 0, 0, 0));
        apply(1, mk("b_seq_up",   1, 0, 0, 0, 0, 3'b110, 9, 0, 0, 0));
        apply(1, mk("b_seq_up1",  1, 0, 0, 0, 0, 3'b100, 0, 1, 0, 1));
        apply(1, mk("b_seq_idle", 1, 0, 0, 0, 0, 3'b000, 0, 0, 0, 1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
